// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO on a valid/ready stream.
// Frames leave back to back while the FIFO holds data; tx idles high.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            not_empty;
    logic            bit_end;

    assign tx_ready   = (count_q != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign not_empty  = (count_q != '0);
    assign bit_end    = (baud_q == BAUD_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || not_empty;
    assign fifo_count = count_q;

    // Every bit boundary reloads the baud counter to zero, so timing never drifts.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (not_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (not_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a flush only has to clear the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a slow (434) and a fast (2) instance
// checked every cycle against a frame-timeline model of the transmitter.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int NB0   = 434;
    localparam int NB1   = 2;
    localparam logic [9:0] PAT37 = 10'b1001101110;
    localparam logic [9:0] PATA5 = 10'b1101001010;

    logic       clock;
    logic       rstn_s     [2];
    logic       tx_valid_s [2];
    logic [7:0] tx_data_s  [2];
    logic       tx_ready_s [2];
    logic       tx_s       [2];
    logic       busy_s     [2];
    logic [2:0] count_s    [2];

    int checks   = 0;
    int failures = 0;

    // Model: a plain list of queued bytes plus the byte and cycle offset of the frame on the wire.
    logic [7:0] mq    [2][DEPTH];
    int         msize [2];
    bit         mact  [2];
    int         mt    [2];
    logic [7:0] mbyte [2];
    bit         macc  [2];

    uart_tx_fifo #(.CLKS_PER_BIT(NB0), .FIFO_DEPTH(DEPTH)) dut_slow (
        .clock(clock), .resetb(rstn_s[0]), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
        .tx_ready(tx_ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .fifo_count(count_s[0])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(NB1), .FIFO_DEPTH(DEPTH)) dut_fast (
        .clock(clock), .resetb(rstn_s[1]), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
        .tx_ready(tx_ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .fifo_count(count_s[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int nbOf(input int i);
        return (i == 0) ? NB0 : NB1;
    endfunction

    function automatic int expTx(input int i);
        int k;
        if (!mact[i]) return 1;
        k = mt[i] / nbOf(i);
        if (k == 0) return 0;
        if (k <= 8) return int'(mbyte[i][k-1]);
        return 1;
    endfunction

    task automatic modelReset(input int i);
        msize[i] = 0;
        mact[i]  = 1'b0;
        mt[i]    = 0;
        macc[i]  = 1'b0;
    endtask

    // One rising edge: finish/advance the frame, start the next from the list, then accept input.
    task automatic modelEdge(input int i);
        int pre;
        pre     = msize[i];
        macc[i] = 1'b0;
        if (!rstn_s[i]) begin
            modelReset(i);
        end else begin
            if (mact[i]) begin
                mt[i]++;
                if (mt[i] == 10 * nbOf(i)) mact[i] = 1'b0;
            end
            if (!mact[i] && pre > 0) begin
                mbyte[i] = mq[i][0];
                for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
                msize[i]--;
                mact[i] = 1'b1;
                mt[i]   = 0;
            end
            if (tx_valid_s[i] && pre != DEPTH) begin
                mq[i][msize[i]] = tx_data_s[i];
                msize[i]++;
                macc[i] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic compareModel();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("cyc_tx%0d", i), int'(tx_s[i]), expTx(i));
            checkOutput($sformatf("cyc_count%0d", i), int'(count_s[i]), msize[i]);
            checkOutput($sformatf("cyc_ready%0d", i), int'(tx_ready_s[i]), (msize[i] != DEPTH) ? 1 : 0);
            checkOutput($sformatf("cyc_busy%0d", i), int'(busy_s[i]), (mact[i] || msize[i] != 0) ? 1 : 0);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        for (int i = 0; i < 2; i++) modelEdge(i);
        @(negedge clock);
        compareModel();
    endtask

    // Push one byte into an idle instance and check the waveform against a hand-written level pattern.
    task automatic runSingle(input int idx, input logic [7:0] want, input logic [9:0] pat);
        int n;
        int k;
        int bad[10];
        int busyGap;
        logic [7:0] dec;
        n       = nbOf(idx);
        busyGap = 0;
        dec     = 8'h00;
        for (int j = 0; j < 10; j++) bad[j] = 0;
        tx_valid_s[idx] = 1'b1;
        tx_data_s[idx]  = want;
        stepCycle();
        tx_valid_s[idx] = 1'b0;
        checkOutput("single_count_after_E0", int'(count_s[idx]), 1);
        stepCycle();
        checkOutput("single_count_after_E1", int'(count_s[idx]), 0);
        for (int j = 0; j < 10 * n; j++) begin
            if (j > 0) stepCycle();
            k = j / n;
            if (tx_s[idx] !== pat[k]) bad[k]++;
            if ((j % n) == (n / 2) && k >= 1 && k <= 8) dec[k-1] = tx_s[idx];
            if (busy_s[idx] !== 1'b1) busyGap++;
        end
        for (int j = 0; j < 10; j++) checkOutput($sformatf("single_level%0d_bad_cycles", j), bad[j], 0);
        checkOutput("single_decoded_byte", int'(dec), int'(want));
        checkOutput("single_busy_gaps", busyGap, 0);
        stepCycle();
        checkOutput("single_busy_after_stop", int'(busy_s[idx]), 0);
    endtask

    initial begin
        int steps;
        int stall;
        int hits;
        int p;
        int guard;
        int maxc;
        logic [7:0] list [20];

        for (int i = 0; i < 2; i++) begin
            rstn_s[i]     = 1'b0;
            tx_valid_s[i] = 1'b0;
            tx_data_s[i]  = 8'h00;
            modelReset(i);
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_tx", int'(tx_s[i]), 1);
            checkOutput("reset_ready", int'(tx_ready_s[i]), 1);
            checkOutput("reset_busy", int'(busy_s[i]), 0);
            checkOutput("reset_count", int'(count_s[i]), 0);
        end
        stepCycle();
        rstn_s[0] = 1'b1;
        rstn_s[1] = 1'b1;
        stepCycle();

        $display("[TB] handshake: data toggles with valid low");
        hits = 0;
        for (int j = 0; j < 40; j++) begin
            tx_data_s[0] = 8'($urandom);
            tx_data_s[1] = 8'($urandom);
            stepCycle();
            for (int i = 0; i < 2; i++)
                if (count_s[i] !== 3'd0 || tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0) hits++;
        end
        checkOutput("idle_toggle_activity", hits, 0);

        $display("[TB] single byte 0x37 at 434 clocks per bit");
        runSingle(0, 8'h37, PAT37);
        $display("[TB] minimum divisor 0xA5 at 2 clocks per bit");
        runSingle(1, 8'hA5, PATA5);

        $display("[TB] fill FIFO");
        steps = 0;
        for (int j = 0; j < 5; j++) begin
            tx_valid_s[0] = 1'b1;
            tx_data_s[0]  = 8'h41 + 8'(j);
            stepCycle();
            steps++;
        end
        checkOutput("fill_count_after5", int'(count_s[0]), 4);
        checkOutput("fill_ready_after5", int'(tx_ready_s[0]), 0);
        tx_data_s[0] = 8'h46;
        stall = 0;
        while (tx_ready_s[0] !== 1'b1 && stall < 20 * NB0) begin
            stepCycle();
            steps++;
            stall++;
        end
        checkOutput("fill_stall_cycles", stall, 10 * NB0 - 3);
        stepCycle();
        steps++;
        tx_valid_s[0] = 1'b0;
        checkOutput("fill_sixth_count", int'(count_s[0]), 4);
        checkOutput("fill_sixth_ready", int'(tx_ready_s[0]), 0);
        while (busy_s[0] === 1'b1 && steps < 80 * NB0) begin
            stepCycle();
            steps++;
        end
        checkOutput("fill_busy_fall_step", steps, 60 * NB0 + 2);

        $display("[TB] pointer wrap: 20 random bytes, valid held high");
        for (int j = 0; j < 20; j++) list[j] = 8'($urandom_range(0, 255));
        p = 0;
        guard = 0;
        maxc = 0;
        while ((p < 20 || busy_s[1] === 1'b1) && guard < 2000) begin
            if (p < 20) begin
                tx_valid_s[1] = 1'b1;
                tx_data_s[1]  = list[p];
            end else begin
                tx_valid_s[1] = 1'b0;
                tx_data_s[1]  = 8'($urandom);
            end
            stepCycle();
            guard++;
            if (macc[1]) p++;
            if (int'(count_s[1]) > maxc) maxc = int'(count_s[1]);
        end
        tx_valid_s[1] = 1'b0;
        checkOutput("wrap_accepted", p, 20);
        checkOutput("wrap_max_count", maxc, 4);
        checkOutput("wrap_drained", int'(busy_s[1]), 0);

        $display("[TB] random valid bursts");
        for (int j = 0; j < 400; j++) begin
            tx_valid_s[1] = ($urandom_range(0, 3) != 0);
            tx_data_s[1]  = 8'($urandom);
            stepCycle();
        end
        tx_valid_s[1] = 1'b0;
        guard = 0;
        while (busy_s[1] === 1'b1 && guard < 200) begin
            stepCycle();
            guard++;
        end
        checkOutput("random_drained", int'(busy_s[1]), 0);

        $display("[TB] reset mid-frame");
        steps = 0;
        tx_valid_s[0] = 1'b1;
        tx_data_s[0] = 8'h55; stepCycle(); steps++;
        tx_data_s[0] = 8'hAA; stepCycle(); steps++;
        tx_data_s[0] = 8'h0F; stepCycle(); steps++;
        tx_valid_s[0] = 1'b0;
        while (steps < 2 + 4 * NB0 + NB0 / 2) begin
            stepCycle();
            steps++;
        end
        checkOutput("rst_pre_tx", int'(tx_s[0]), 0);
        checkOutput("rst_pre_count", int'(count_s[0]), 2);
        rstn_s[0] = 1'b0;
        #1;
        modelReset(0);
        checkOutput("rst_tx", int'(tx_s[0]), 1);
        checkOutput("rst_count", int'(count_s[0]), 0);
        checkOutput("rst_busy", int'(busy_s[0]), 0);
        checkOutput("rst_ready", int'(tx_ready_s[0]), 1);
        repeat (3) stepCycle();
        rstn_s[0] = 1'b1;
        stepCycle();
        runSingle(0, 8'h37, PAT37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable 8N1 UART transmitter with a small input FIFO for the user project area. It takes bytes from a valid/ready stream and serializes them onto a `mprj_io` pad (UART TX, pin 6 in the standard pinout). It is the driving end of the serial link that the testbench UART receiver model samples at 115200 baud. Frames are sent back to back with no idle gap while the FIFO holds data.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2 to 65535.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Must be a power of 2, 2 to 16.

Ports:

- `clock`  in  1  system clock, rising edge.
- `resetb`  in  1  asynchronous reset, active low; release is synchronous to `clock`.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept; a transfer happens when `tx_valid && tx_ready` at a rising edge.
- `tx`  out  1  serial line; idle high; registered output.
- `busy`  out  1  FIFO non-empty or a frame in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0. Reset also clears the FSM to IDLE and the bit and baud counters to 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - `tx_ready` = (`fifo_count` != `FIFO_DEPTH`). There is no bypass: when full, `tx_ready` stays low even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - `tx_data` is ignored when `tx_valid` is low or `tx_ready` is low.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO is non-empty: pop the head into the shift register, drive `tx`=0, go to START.
  - START: hold for `CLKS_PER_BIT` cycles, then drive `tx`=shift[0] and go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. Shift right after each bit. A 3-bit bit counter wraps 7→0 on exit. Then drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. At the end: if FIFO is non-empty, pop and go directly to START with `tx`=0. Otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1 and reloads 0 on every bit boundary, so there is no cumulative drift.
- `busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing

- Latency:
  - Byte accepted at edge E0 into an empty FIFO with FSM in IDLE → popped at E1.
  - `tx` goes low after E1, one cycle of latency.
  - `fifo_count` reads 1 after E0 and 0 after E1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles per frame (start, 8 data, stop).
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- Data popped at frame start is latched in the shift register. FIFO activity during the frame does not disturb `tx`.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously, the FIFO is flushed, and the partial frame is abandoned. After `resetb` rises, the first accepted byte behaves as in the latency rule above.

## Test plan

- **Single byte.** `CLKS_PER_BIT`=434. Push 0x37 ('7') when idle.
  - `tx` sequence 0,1,1,1,0,1,1,0,0,1, each level 434 cycles; frame is 4340 cycles.
  - A receiver model at 115200 baud decodes '7'.
  - `busy` falls on the cycle after the stop bit ends.
- **Fill FIFO.** `FIFO_DEPTH`=4. Push 0x41..0x45 on 5 consecutive cycles from idle.
  - All 5 are accepted (the first is popped at E1).
  - `tx_ready` drops after the 5th push, with `fifo_count`=4.
  - A 6th push stalls until the stop bit of 0x41 ends.
  - Bytes are then sent in order with no idle gap between frames.
- **Pointer wrap.** Stream 20 random bytes while holding `tx_valid` high continuously.
  - The serial output matches the input order exactly.
  - `fifo_count` never exceeds 4 and never underflows.
- **Minimum divisor.** `CLKS_PER_BIT`=2. Push 0xA5.
  - `tx` pattern 0,1,0,1,0,0,1,0,1,1, each level 2 cycles; frame is 20 cycles total.
- **Reset mid-frame.** Assert `resetb`=0 during data bit 3 of 0x55 with 2 bytes still queued.
  - Immediately: `tx`=1, `fifo_count`=0, `busy`=0, `tx_ready`=1.
  - After release, pushing 0x37 reproduces the single-byte waveform.
- **Handshake hygiene.**
  - Toggle `tx_data` while `tx_valid`=0: nothing is transmitted and `fifo_count` stays 0.
  - Hold `tx_valid`=1 while full: exactly one entry is accepted per freed slot.
